// File: rtl/divider_sequencer.sv
// divider_sequencer: multi-cycle 32-bit restoring divider with a valid/ready
// request port and a valid/ready result port. Handles DIVU/REMU/DIV/REM,
// with signed ops divided as magnitudes and the result sign-corrected on the
// final iteration edge.
module divider_sequencer #(
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [31:0] rem_r, quo_r, dvd_r, dvs_r, res_r;
    logic        op_rem, neg_q, neg_r;

    // Request-side decode: magnitudes and sign flags for signed ops.
    logic        sgn, a_neg, b_neg, div_zero, last;
    logic [31:0] abs_a, abs_b;

    assign sgn      = i_op[1];
    assign a_neg    = sgn & i_dividend[31];
    assign b_neg    = sgn & i_divisor[31];
    assign abs_a    = a_neg ? -i_dividend : i_dividend;
    assign abs_b    = b_neg ? -i_divisor  : i_divisor;
    assign div_zero = (i_divisor == 32'd0);
    assign last     = (cnt == 6'(32 - ITERS_PER_CYCLE));

    // Restoring iterations for one RUN cycle, MSB-first. The shifted partial
    // remainder is kept 33 bits wide so a large divisor never loses its top bit.
    logic [31:0] rem_nx, quo_nx, dvd_nx;
    logic [32:0] shf, diff;

    always_comb begin
        rem_nx = rem_r;
        quo_nx = quo_r;
        dvd_nx = dvd_r;
        shf    = '0;
        diff   = '0;
        for (int k = 0; k < ITERS_PER_CYCLE; k++) begin
            shf    = {rem_nx, dvd_nx[31]};
            dvd_nx = {dvd_nx[30:0], 1'b0};
            diff   = shf - {1'b0, dvs_r};
            if (shf >= {1'b0, dvs_r}) begin
                rem_nx = diff[31:0];
                quo_nx = {quo_nx[30:0], 1'b1};
            end else begin
                rem_nx = shf[31:0];
                quo_nx = {quo_nx[30:0], 1'b0};
            end
        end
    end

    // Sign-corrected final values, taken on the edge completing iteration 32.
    logic [31:0] fin_q, fin_r;
    assign fin_q = neg_q ? -quo_nx : quo_nx;
    assign fin_r = neg_r ? -rem_nx : rem_nx;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: divide-by-zero skips RUN entirely.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_valid) state_nx = div_zero ? DONE : RUN;
            RUN:     if (last)    state_nx = DONE;
            DONE:    if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in RUN, capture result on the way out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            dvd_r  <= '0;
            dvs_r  <= '0;
            res_r  <= '0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    cnt    <= '0;
                    rem_r  <= '0;
                    quo_r  <= '0;
                    dvd_r  <= abs_a;
                    dvs_r  <= abs_b;
                    op_rem <= i_op[0];
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    if (div_zero) res_r <= i_op[0] ? i_dividend : 32'hFFFF_FFFF;
                end
                RUN: begin
                    cnt   <= cnt + 6'(ITERS_PER_CYCLE);
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    dvd_r <= dvd_nx;
                    if (last) res_r <= op_rem ? fin_r : fin_q;
                end
                default: ;
            endcase
        end
    end

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_busy   = !o_ready;
    assign o_result = (state == DONE) ? res_r : 32'd0;

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer: one instance at 1 iteration/cycle and
// one at 4 iterations/cycle, hand-computed vectors plus a reference model for
// random operands on the wide instance.
module tb_divider_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        v1, v4, irdy;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        or1, ov1, ob1, or4, ov4, ob4;
    logic [31:0] r1, r4;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    divider_sequencer #(.ITERS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .o_ready(or1), .i_op(op),
        .i_dividend(a), .i_divisor(b), .o_valid(ov1), .i_ready(irdy),
        .o_result(r1), .o_busy(ob1)
    );

    divider_sequencer #(.ITERS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(v4), .o_ready(or4), .i_op(op),
        .i_dividend(a), .i_divisor(b), .o_valid(ov4), .i_ready(irdy),
        .o_result(r4), .o_busy(ob4)
    );

    function automatic logic rdy_of(input int sel);
        return (sel == 1) ? or1 : or4;
    endfunction
    function automatic logic vld_of(input int sel);
        return (sel == 1) ? ov1 : ov4;
    endfunction
    function automatic logic bsy_of(input int sel);
        return (sel == 1) ? ob1 : ob4;
    endfunction
    function automatic logic [31:0] res_of(input int sel);
        return (sel == 1) ? r1 : r4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the operation definitions.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ax, ay, q, r;
        logic        nx, ny;
        if (y == 32'd0) return o[0] ? x : 32'hFFFF_FFFF;
        nx = o[1] & x[31];
        ny = o[1] & y[31];
        ax = nx ? -x : x;
        ay = ny ? -y : y;
        q  = ax / ay;
        r  = ax % ay;
        if (o[0]) return nx ? -r : r;
        return (nx ^ ny) ? -q : q;
    endfunction

    // Present a request at negedge; returns #1 after the accepting edge.
    task automatic issue(input int sel, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input string tag);
        @(negedge clk);
        op = o; a = x; b = y;
        chk({tag, "_rdy"}, 32'(rdy_of(sel)), 32'd1);
        if (sel == 1) v1 = 1'b1; else v4 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0; v4 = 1'b0;
        chk({tag, "_busy"}, 32'(bsy_of(sel)), 32'd1);
        if (!vld_of(sel)) chk({tag, "_res_run"}, res_of(sel), 32'd0);
    endtask

    // Count edges after the accepting edge until o_valid (0 = DONE on accept).
    task automatic wait_res(input int sel, input int lat, input logic [31:0] exp, input string tag);
        int e = 0;
        while (!vld_of(sel) && e < 200) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk({tag, "_lat"}, 32'(e), 32'(lat));
        chk({tag, "_res"}, res_of(sel), exp);
    endtask

    task automatic retire(input int sel, input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_retired"}, 32'(rdy_of(sel)), 32'd1);
        chk({tag, "_res_idle"}, res_of(sel), 32'd0);
    endtask

    task automatic do_op(input int sel, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input string tag);
        int lat;
        lat = (y == 32'd0) ? 0 : ((sel == 1) ? 32 : 8);
        issue(sel, o, x, y, tag);
        wait_res(sel, lat, exp, tag);
        retire(sel, tag);
    endtask

    initial begin
        rst = 1'b1; irdy = 1'b1; v1 = 1'b0; v4 = 1'b0;
        op = 2'b00; a = '0; b = '0;
        #12;
        chk("rst_ready", 32'(or1), 32'd1);
        chk("rst_valid", 32'(ov1), 32'd0);
        chk("rst_busy",  32'(ob1), 32'd0);
        chk("rst_res",   r1, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic unsigned and signed cases, 1 iteration per cycle.
        do_op(1, 2'b00, 32'd100, 32'd7, 32'd14, "divu_100_7");
        do_op(1, 2'b01, 32'd100, 32'd7, 32'd2,  "remu_100_7");
        do_op(1, 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "div_m100_7");
        do_op(1, 2'b11, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, "rem_m100_7");
        do_op(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(1, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
        do_op(1, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, "divu_bigdvs");

        // Divide by zero: DONE directly on the accepting edge.
        do_op(1, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        do_op(1, 2'b11, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, "rem_by0");

        // Backpressure: hold result for 10 cycles while requests are offered.
        irdy = 1'b0;
        issue(1, 2'b00, 32'd1000, 32'd10, "bp");
        wait_res(1, 32, 32'd100, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v1 = 1'b1; op = 2'b01; a = 32'd77 + 32'(i); b = 32'd3;
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(ov1), 32'd1);
            chk("bp_hold_res",   r1, 32'd100);
            chk("bp_hold_ready", 32'(or1), 32'd0);
        end
        @(negedge clk);
        v1 = 1'b0; irdy = 1'b1;
        retire(1, "bp");
        issue(1, 2'b01, 32'd50, 32'd8, "bp_next");
        wait_res(1, 32, 32'd2, "bp_next");
        retire(1, "bp_next");

        // Reset in the middle of RUN discards the operation.
        issue(1, 2'b00, 32'h1234_5678, 32'd3, "rst_run");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_run_ready", 32'(or1), 32'd1);
        chk("rst_run_valid", 32'(ov1), 32'd0);
        chk("rst_run_busy",  32'(ob1), 32'd0);
        chk("rst_run_res",   r1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_run_noresult", 32'(ov1), 32'd0);
        do_op(1, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "after_rst");

        // 4 iterations per cycle: directed then random against the model.
        do_op(4, 2'b00, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, "w4_divu");
        do_op(4, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "w4_div_ovf");
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'(i % 4);
            x = $urandom;
            case (i % 6)
                0:       y = 32'($urandom_range(1, 255));
                1:       y = -32'($urandom_range(1, 255));
                5:       y = (i == 5) ? 32'd0 : $urandom;
                default: y = $urandom;
            endcase
            do_op(4, o, x, y, ref_div(o, x, y), "w4_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
